time_update_sched: RTL
======================

Name: time_update_sched

Overview:
- Sequences the MM:SS BCD time registers of the clock.
- Converts 1 Hz run ticks and 2 Hz adjust ticks from the mode controller into digit updates.
- Uses one shared BCD digit incrementer, walking the carry chain one digit per cycle.
- Sits between the tick dividers/mode control FSM and the display mux; owns the four digit registers.

Parameters:
- SEC_TENS_MAX, 5, wrap value of the seconds-tens digit (x5 -> 0).
- MIN_TENS_MAX, 9, wrap value of the minutes-tens digit (99:59 -> 00:00).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low (clears on rst=0)
- tick_1hz  in  1  single-cycle run tick
- tick_2hz  in  1  single-cycle adjust tick
- count_enable  in  1  run counting allowed
- sel_minutes  in  1  adjust minutes field
- sel_seconds  in  1  adjust seconds field
- clr  in  1  synchronous clear of time to 00:00
- min_tens  out  4  BCD minutes tens
- min_ones  out  4  BCD minutes ones
- sec_tens  out  4  BCD seconds tens
- sec_ones  out  4  BCD seconds ones
- busy  out  1  update sequence in flight
- upd_done  out  1  one-cycle pulse, sequence finished
- tick_drop  out  1  one-cycle pulse, a qualifying tick was discarded

Behaviour:
- Reset (rst=0, async): all digits 0, state IDLE, busy=0, upd_done=0, tick_drop=0, pending=0.
- FSM states: IDLE, SO (sec ones), ST (sec tens), MO (min ones), MT (min tens).
- busy = (state != IDLE).
- All outputs are registered.
- Qualifying tick, sampled in IDLE, priority order:
  - sel_minutes & tick_2hz -> op ADJ_MIN
  - else sel_seconds & tick_2hz -> op ADJ_SEC
  - else count_enable & tick_1hz -> op RUN
- Op kind is latched at acceptance; input changes mid-sequence are ignored.
- Start state: RUN and ADJ_SEC start at SO; ADJ_MIN starts at MO.
- Each step state spends one cycle and writes its digit at the exiting edge:
  - SO: 9 -> 0 with carry, else +1 with no carry.
  - ST: SEC_TENS_MAX -> 0 with carry, else +1.
  - MO: 9 -> 0 with carry, else +1.
  - MT: MIN_TENS_MAX -> 0, else +1; never carries.
- Carry routing:
  - RUN: SO -> ST -> MO -> MT.
  - ADJ_SEC: ST carry is discarded (seconds wrap, minutes untouched).
  - ADJ_MIN: MO -> MT, with MT wrapping.
- No carry, or end of chain -> IDLE; upd_done=1 for the following cycle.
- Latency: tick high in cycle 0 -> busy in cycle 1 -> k step cycles -> upd_done in cycle k+1.
  - k = 1..4 for RUN, 1..2 for adjust.
- Digits are guaranteed consistent only when busy=0.
- A qualifying tick while busy=1 (including the final step cycle) is not started.
  - It is dropped with tick_drop pulsed the next cycle, unless queued (see Optional Feature).
- A new tick in the upd_done cycle is accepted normally.
- clr=1 (sync, highest priority after rst): digits -> 0, state -> IDLE, pending -> 0, no upd_done, ticks that cycle ignored.
- Out-of-range digits are not corrected; any value >= the wrap value wraps to 0 on increment.

Optional Feature:
- Macro: TIME_UPDATE_TICK_QUEUE_EN.
- Defined:
  - A 2-bit saturating pending counter holds RUN ticks that arrive while busy.
  - On return to IDLE with pending > 0, a RUN op is dispatched the next cycle, if it is still qualified by count_enable, and pending decrements.
  - A RUN tick arriving at pending=3 pulses tick_drop.
  - Adjust ticks arriving while busy are always dropped.
  - Pending is cleared on any adjust op acceptance.
- Undefined: no pending storage; every qualifying tick arriving while busy pulses tick_drop.

Test Plan:
- Reset mid-sequence: RUN tick from 09:59, assert rst=0 in the second step cycle -> digits 00:00 immediately, busy=0, no upd_done.
- Simple run: time 00:00, count_enable=1, one tick_1hz -> busy for 1 cycle, 00:01, upd_done 2 cycles after the tick.
- Full carry: 09:59 + tick_1hz -> 4 busy cycles (SO, ST, MO, MT), result 10:00; 99:59 + tick -> 00:00.
- Adjust seconds: 12:59, sel_seconds=1, tick_2hz -> 12:00, minutes unchanged, 2 busy cycles; sel_minutes=1 at 99:30 + tick_2hz -> 00:30.
- Busy collision: tick_1hz at 09:59, second tick_1hz 2 cycles later.
  - Macro undefined -> tick_drop pulse, final 10:00.
  - Macro defined -> second op runs after upd_done, final 10:01.
  - Macro defined, 4 ticks while busy -> 3 queued, 1 tick_drop.
- Clear priority: clr=1 coincident with tick_1hz during SO -> 00:00, busy=0 next cycle, no upd_done, pending=0.

Source files
------------

// File: rtl/time_update_sched_if.sv
// Handshake/bus bundle between the mode controller, the time update sequencer
// and the display mux: tick/mode inputs, BCD digit outputs and status pulses.
interface time_update_sched_if;
    logic       tick_1hz;
    logic       tick_2hz;
    logic       count_enable;
    logic       sel_minutes;
    logic       sel_seconds;
    logic       clr;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       busy;
    logic       upd_done;
    logic       tick_drop;

    modport master (
        output tick_1hz, tick_2hz, count_enable, sel_minutes, sel_seconds, clr,
        input  min_tens, min_ones, sec_tens, sec_ones, busy, upd_done, tick_drop
    );

    modport slave (
        input  tick_1hz, tick_2hz, count_enable, sel_minutes, sel_seconds, clr,
        output min_tens, min_ones, sec_tens, sec_ones, busy, upd_done, tick_drop
    );
endinterface

// File: rtl/time_update_sched.sv
// MM:SS BCD time register sequencer: walks one shared digit incrementer along the
// carry chain, one digit per cycle. Optional RUN-tick queue: TIME_UPDATE_TICK_QUEUE_EN.
module time_update_sched #(
    parameter logic [3:0] SEC_TENS_MAX = 4'd5,
    parameter logic [3:0] MIN_TENS_MAX = 4'd9
) (
    input logic                clk,
    input logic                rst,
    time_update_sched_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SO, ST, MO, MT} state_t;
    typedef enum logic [1:0] {OP_RUN, OP_ADJ_SEC, OP_ADJ_MIN} op_t;

    state_t     state;
    op_t        op;
    logic [3:0] min_tens_q, min_ones_q, sec_tens_q, sec_ones_q;
    logic       busy_q, upd_done_q, tick_drop_q;

    // Tick qualification in priority order: minutes adjust, seconds adjust, run.
    logic adj_min_tick, adj_sec_tick, run_tick, busy_state;
    assign adj_min_tick = bus.sel_minutes & bus.tick_2hz;
    assign adj_sec_tick = ~adj_min_tick & bus.sel_seconds & bus.tick_2hz;
    assign run_tick     = ~adj_min_tick & ~adj_sec_tick & bus.count_enable & bus.tick_1hz;
    assign busy_state   = (state != IDLE);

    logic pend_dispatch;
    logic tick_lost;

`ifdef TIME_UPDATE_TICK_QUEUE_EN
    logic [1:0] pending;

    assign pend_dispatch = (state == IDLE) && (pending != 2'd0) && bus.count_enable;
    assign tick_lost     = busy_state &&
                           (adj_min_tick || adj_sec_tick || (run_tick && pending == 2'd3));

    // A RUN tick arriving in IDLE while a queued tick dispatches takes its place in the queue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= 2'd0;
        end else if (bus.clr) begin
            pending <= 2'd0;
        end else if (state == IDLE) begin
            if (adj_min_tick || adj_sec_tick)
                pending <= 2'd0;
            else if (pend_dispatch && !run_tick)
                pending <= pending - 2'd1;
        end else if (run_tick && pending != 2'd3) begin
            pending <= pending + 2'd1;
        end
    end
`else
    assign pend_dispatch = 1'b0;
    assign tick_lost     = busy_state && (adj_min_tick || adj_sec_tick || run_tick);
`endif

    // Op selection at acceptance; only meaningful in IDLE.
    logic start;
    op_t  start_op;
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        start    = 1'b0;
        start_op = OP_RUN;
        if (state == IDLE) begin
            if (adj_min_tick) begin
                start    = 1'b1;
                start_op = OP_ADJ_MIN;
            end else if (adj_sec_tick) begin
                start    = 1'b1;
                start_op = OP_ADJ_SEC;
            end else if (run_tick || pend_dispatch) begin
                start    = 1'b1;
            end
        end
    end

    // Shared digit incrementer, fed by whichever digit the current step owns.
    logic [3:0] inc_in, inc_max, inc_out;
    logic       inc_carry;
    always_comb begin
        inc_in  = sec_ones_q;
        inc_max = 4'd9;
        case (state)
            ST: begin
                inc_in  = sec_tens_q;
                inc_max = SEC_TENS_MAX;
            end
            MO: begin
                inc_in  = min_ones_q;
                inc_max = 4'd9;
            end
            MT: begin
                inc_in  = min_tens_q;
                inc_max = MIN_TENS_MAX;
            end
            default: ;
        endcase
        if (inc_in >= inc_max) begin
            inc_out   = 4'd0;
            inc_carry = 1'b1;
        end else begin
            inc_out   = inc_in + 4'd1;
            inc_carry = 1'b0;
        end
    end

    // Carry routing: seconds adjust stops at ST, minutes tens never carries.
    state_t step_next;
    always_comb begin
        step_next = IDLE;
        case (state)
            SO:      if (inc_carry) step_next = ST;
            ST:      if (inc_carry && op == OP_RUN) step_next = MO;
            MO:      if (inc_carry) step_next = MT;
            default: step_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst) begin
            state       <= IDLE;
            op          <= OP_RUN;
            min_tens_q  <= 4'd0;
            min_ones_q  <= 4'd0;
            sec_tens_q  <= 4'd0;
            sec_ones_q  <= 4'd0;
            busy_q      <= 1'b0;
            upd_done_q  <= 1'b0;
            tick_drop_q <= 1'b0;
        end else if (bus.clr) begin
            state       <= IDLE;
            min_tens_q  <= 4'd0;
            min_ones_q  <= 4'd0;
            sec_tens_q  <= 4'd0;
            sec_ones_q  <= 4'd0;
            busy_q      <= 1'b0;
            upd_done_q  <= 1'b0;
            tick_drop_q <= 1'b0;
        end else begin
            upd_done_q  <= 1'b0;
            tick_drop_q <= tick_lost;
            if (state == IDLE) begin
                if (start) begin
                    op     <= start_op;
                    state  <= (start_op == OP_ADJ_MIN) ? MO : SO;
                    busy_q <= 1'b1;
                end
            end else begin
                case (state)
                    SO:      sec_ones_q <= inc_out;
                    ST:      sec_tens_q <= inc_out;
                    MO:      min_ones_q <= inc_out;
                    MT:      min_tens_q <= inc_out;
                    default: ;
                endcase
                state      <= step_next;
                busy_q     <= (step_next != IDLE);
                upd_done_q <= (step_next == IDLE);
            end
        end
    end

    assign bus.min_tens  = min_tens_q;
    assign bus.min_ones  = min_ones_q;
    assign bus.sec_tens  = sec_tens_q;
    assign bus.sec_ones  = sec_ones_q;
    assign bus.busy      = busy_q;
    assign bus.upd_done  = upd_done_q;
    assign bus.tick_drop = tick_drop_q;
endmodule
